// File: rtl/rpc2_ctrl_dpram_fifo_ctrl_if.sv
// Valid/ready handshake bundle for the write and read sides of the
// DPRAM-backed FIFO controller. The controller takes the slave view.
interface rpc2_ctrl_dpram_fifo_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/rpc2_ctrl_dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller wrapped around a dual-port RAM
// with a registered read port. The RAM output register doubles as the head
// register, so capacity is D words in the RAM plus one on the output.
module rpc2_ctrl_dpram_fifo_ctrl #(
    parameter int FIFO_ADDR_BITS  = 3,
    parameter int FIFO_DATA_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    rpc2_ctrl_dpram_fifo_if.slave      fifo,
    output logic [FIFO_ADDR_BITS:0]    count,
    output logic                       ram_ceia_n,
    output logic [FIFO_ADDR_BITS-1:0]  ram_ia,
    output logic [FIFO_DATA_WIDTH-1:0] ram_idata,
    output logic                       ram_cejb_n,
    output logic [FIFO_ADDR_BITS-1:0]  ram_jb,
    input  logic [FIFO_DATA_WIDTH-1:0] ram_odata
);

    localparam logic [FIFO_ADDR_BITS:0]   DEPTH     = {1'b1, {FIFO_ADDR_BITS{1'b0}}};
    localparam logic [FIFO_ADDR_BITS:0]   WORDS_ONE = (FIFO_ADDR_BITS+1)'(1);
    localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE   = FIFO_ADDR_BITS'(1);

    logic [FIFO_ADDR_BITS-1:0] wptr;
    logic [FIFO_ADDR_BITS-1:0] rptr;
    logic [FIFO_ADDR_BITS:0]   ram_words;
    logic                      rd_valid_q;

    logic wr_ready;
    logic wr_fire;
    logic rd_fire;
    logic rd_issue;

    // Handshake decode: writes stop when the RAM is full, reads are issued
    // whenever a stored word exists and the output slot is free or draining.
    // Only words committed at an earlier edge are counted in ram_words, so a
    // word can never be read in the cycle it is written.
    always_comb begin
        wr_ready = !reset && !flush && (ram_words != DEPTH);
        wr_fire  = fifo.wr_valid && wr_ready;
        rd_fire  = rd_valid_q && fifo.rd_ready;
        rd_issue = !reset && !flush && (ram_words != '0) && (!rd_valid_q || fifo.rd_ready);
    end

    // RAM port drive and consumer-side outputs; read data comes straight
    // from the RAM output register, which holds while port B is disabled.
    always_comb begin
        ram_ceia_n    = !wr_fire;
        ram_ia        = wptr;
        ram_idata     = fifo.wr_data;
        ram_cejb_n    = !rd_issue;
        ram_jb        = rptr;
        fifo.wr_ready = wr_ready;
        fifo.rd_valid = rd_valid_q;
        fifo.rd_data  = ram_odata;
        count         = ram_words + {{FIFO_ADDR_BITS{1'b0}}, rd_valid_q};
    end

    // Pointer, occupancy and head-valid state; flush empties the FIFO at the
    // edge, and any head taken during the flush cycle is still a transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            ram_words  <= '0;
            rd_valid_q <= 1'b0;
        end else if (flush) begin
            wptr       <= '0;
            rptr       <= '0;
            ram_words  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_issue) begin
                rptr <= rptr + PTR_ONE;
            end
            if (wr_fire && !rd_issue) begin
                ram_words <= ram_words + WORDS_ONE;
            end else if (!wr_fire && rd_issue) begin
                ram_words <= ram_words - WORDS_ONE;
            end
            rd_valid_q <= rd_issue || (rd_valid_q && !rd_fire);
        end
    end

endmodule

// File: tb/tb_rpc2_ctrl_dpram_fifo_ctrl.sv
// Self-checking bench for the DPRAM FIFO controller: a behavioural RAM with a
// registered read port, plus a queue-level reference model of the FIFO.
module tb_rpc2_ctrl_dpram_fifo_ctrl;

    localparam int AW = 3;
    localparam int DW = 16;
    localparam int D  = 1 << AW;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [AW:0]   count;
    logic          ram_ceia_n;
    logic [AW-1:0] ram_ia;
    logic [DW-1:0] ram_idata;
    logic          ram_cejb_n;
    logic [AW-1:0] ram_jb;
    logic [DW-1:0] ram_odata;

    rpc2_ctrl_dpram_fifo_if #(.DATA_WIDTH(DW)) bus();

    rpc2_ctrl_dpram_fifo_ctrl #(
        .FIFO_ADDR_BITS (AW),
        .FIFO_DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .fifo      (bus),
        .count     (count),
        .ram_ceia_n(ram_ceia_n),
        .ram_ia    (ram_ia),
        .ram_idata (ram_idata),
        .ram_cejb_n(ram_cejb_n),
        .ram_jb    (ram_jb),
        .ram_odata (ram_odata)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port RAM: synchronous write, registered read that holds when disabled
    logic [DW-1:0] mem [0:D-1];
    always @(posedge clk) begin
        if (!ram_ceia_n) mem[ram_ia] <= ram_idata;
        if (!ram_cejb_n) ram_odata <= mem[ram_jb];
    end

    int checks = 0;
    int errors = 0;

    // Reference model: every accepted entry sits in q; 'shown' marks that q[0]
    // is presented on the output. Entries not shown are the words held in RAM.
    logic [DW-1:0] q[$];
    bit            shown = 0;
    bit            exp_wr_ready, exp_rd_valid, exp_ceia_n, exp_cejb_n;
    logic [AW:0]   exp_count;
    logic [DW-1:0] exp_head;

    // Drive one cycle of inputs at the falling edge and derive expectations
    task automatic set_inputs(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit fl);
        int words;
        @(negedge clk);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        flush        = fl;
        #1;
        words        = q.size() - int'(shown);
        exp_rd_valid = shown;
        exp_count    = (AW+1)'(q.size());
        exp_wr_ready = !reset && !fl && (words < D);
        exp_ceia_n   = !(wv && exp_wr_ready);
        exp_cejb_n   = !(!reset && !fl && (words > 0) && (!shown || rr));
        exp_head     = shown ? q[0] : '0;
    endtask

    // Advance the model across the rising edge
    task automatic clock_edge();
        bit issue;
        bit fire;
        logic [DW-1:0] taken;
        @(posedge clk);
        if (reset) begin
            q.delete();
            shown = 0;
        end else begin
            issue = !exp_cejb_n;
            fire  = shown && bus.rd_ready;
            if (fire) taken = q.pop_front();
            if (!exp_ceia_n) q.push_back(bus.wr_data);
            if (flush) begin
                q.delete();
                shown = 0;
            end else begin
                shown = issue || (shown && !bus.rd_ready);
            end
        end
    endtask

    task automatic test_reset();
        set_inputs(0, '0, 0, 0);
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_ready got %b exp 0", bus.wr_ready); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid got %b exp 0", bus.rd_valid); end
        checks++; if (count !== '0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", count); end
        checks++; if (ram_ceia_n !== 1'b1 || ram_cejb_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_enables got %b%b exp 11", ram_ceia_n, ram_cejb_n); end
        checks++; if (ram_ia !== '0 || ram_jb !== '0) begin errors++; $display("[TB] FAIL reset_addr got ia %0d jb %0d exp 0 0", ram_ia, ram_jb); end
        clock_edge();
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_inputs(0, '0, 0, 0);
            checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_wr_ready c%0d got %b exp 1", i, bus.wr_ready); end
            checks++; if (bus.rd_valid !== 1'b0 || count !== '0) begin errors++; $display("[TB] FAIL idle_empty c%0d got valid %b count %0d exp 0 0", i, bus.rd_valid, count); end
            checks++; if (ram_ceia_n !== 1'b1 || ram_cejb_n !== 1'b1) begin errors++; $display("[TB] FAIL idle_enables c%0d got %b%b exp 11", i, ram_ceia_n, ram_cejb_n); end
            clock_edge();
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 10; i++) begin
            set_inputs(1, DW'(i + 1), 0, 0);
            checks++; if (bus.rd_valid !== (i >= 2)) begin errors++; $display("[TB] FAIL fill_rd_valid c%0d got %b exp %b", i, bus.rd_valid, (i >= 2)); end
            if (i >= 2) begin
                checks++; if (bus.rd_data !== 16'h0001) begin errors++; $display("[TB] FAIL fill_head c%0d got %h exp 0001", i, bus.rd_data); end
            end
            checks++; if (count !== exp_count) begin errors++; $display("[TB] FAIL fill_count c%0d got %0d exp %0d", i, count, exp_count); end
            checks++; if (bus.wr_ready !== (i < 9)) begin errors++; $display("[TB] FAIL fill_wr_ready c%0d got %b exp %b", i, bus.wr_ready, (i < 9)); end
            if (i == 9) begin
                checks++; if (count !== 4'd9) begin errors++; $display("[TB] FAIL fill_full_count got %0d exp 9", count); end
                checks++; if (ram_ceia_n !== 1'b1) begin errors++; $display("[TB] FAIL fill_ignored_write got ceia_n %b exp 1", ram_ceia_n); end
            end
            clock_edge();
        end
        for (int i = 0; i < 9; i++) begin
            set_inputs(0, '0, 1, 0);
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== DW'(i + 1)) begin errors++; $display("[TB] FAIL drain_data c%0d got valid %b data %h exp 1 %h", i, bus.rd_valid, bus.rd_data, DW'(i + 1)); end
            clock_edge();
        end
        set_inputs(0, '0, 1, 0);
        checks++; if (count !== '0 || bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty got count %0d valid %b exp 0 0", count, bus.rd_valid); end
        clock_edge();
    endtask

    task automatic test_streaming();
        logic [DW-1:0] base;
        base = DW'($urandom);
        for (int i = 0; i < 40; i++) begin
            set_inputs(1, base + DW'(i), 1, 0);
            checks++; if (bus.rd_valid !== (i >= 2)) begin errors++; $display("[TB] FAIL stream_valid c%0d got %b exp %b", i, bus.rd_valid, (i >= 2)); end
            if (i >= 2) begin
                checks++; if (bus.rd_data !== base + DW'(i - 2)) begin errors++; $display("[TB] FAIL stream_data c%0d got %h exp %h", i, bus.rd_data, base + DW'(i - 2)); end
            end
            if (i >= 1) begin
                checks++; if (count !== 4'd1 && count !== 4'd2) begin errors++; $display("[TB] FAIL stream_count c%0d got %0d exp 1 or 2", i, count); end
            end
            clock_edge();
        end
        for (int i = 0; i < 3; i++) begin
            set_inputs(0, '0, 1, 0);
            checks++; if (bus.rd_valid !== exp_rd_valid || count !== exp_count) begin errors++; $display("[TB] FAIL stream_drain c%0d got valid %b count %0d exp %b %0d", i, bus.rd_valid, count, exp_rd_valid, exp_count); end
            if (exp_rd_valid) begin
                checks++; if (bus.rd_data !== exp_head) begin errors++; $display("[TB] FAIL stream_drain_data c%0d got %h exp %h", i, bus.rd_data, exp_head); end
            end
            clock_edge();
        end
    endtask

    task automatic test_backpressure();
        set_inputs(1, 16'h00AA, 0, 0); clock_edge();
        set_inputs(0, '0, 0, 0);       clock_edge();
        for (int i = 0; i < 4; i++) begin
            set_inputs(i == 0, 16'h00BB, 0, 0);
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h00AA) begin errors++; $display("[TB] FAIL bp_hold c%0d got valid %b data %h exp 1 00aa", i, bus.rd_valid, bus.rd_data); end
            checks++; if (ram_cejb_n !== 1'b1) begin errors++; $display("[TB] FAIL bp_cejb c%0d got %b exp 1", i, ram_cejb_n); end
            clock_edge();
        end
        set_inputs(0, '0, 1, 0);
        checks++; if (bus.rd_data !== 16'h00AA || ram_cejb_n !== 1'b0) begin errors++; $display("[TB] FAIL bp_release got data %h cejb_n %b exp 00aa 0", bus.rd_data, ram_cejb_n); end
        clock_edge();
        set_inputs(0, '0, 1, 0);
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h00BB) begin errors++; $display("[TB] FAIL bp_next got valid %b data %h exp 1 00bb", bus.rd_valid, bus.rd_data); end
        clock_edge();
        set_inputs(0, '0, 0, 0);
        checks++; if (count !== '0) begin errors++; $display("[TB] FAIL bp_empty got count %0d exp 0", count); end
        clock_edge();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            set_inputs(1, 16'h0F00 + DW'(i), 0, 0); clock_edge();
        end
        set_inputs(0, '0, 0, 1);
        checks++; if (count !== 4'd5) begin errors++; $display("[TB] FAIL flush_pre_count got %0d exp 5", count); end
        checks++; if (bus.wr_ready !== 1'b0 || ram_cejb_n !== 1'b1) begin errors++; $display("[TB] FAIL flush_cycle got wr_ready %b cejb_n %b exp 0 1", bus.wr_ready, ram_cejb_n); end
        clock_edge();
        set_inputs(1, 16'h1234, 0, 0);
        checks++; if (count !== '0 || bus.rd_valid !== 1'b0 || bus.wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_after got count %0d valid %b wr_ready %b exp 0 0 1", count, bus.rd_valid, bus.wr_ready); end
        clock_edge();
        set_inputs(0, '0, 0, 0); clock_edge();
        set_inputs(0, '0, 1, 0);
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h1234) begin errors++; $display("[TB] FAIL flush_readback got valid %b data %h exp 1 1234", bus.rd_valid, bus.rd_data); end
        clock_edge();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) begin
            set_inputs(1, DW'($urandom), 1, 0); clock_edge();
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.rd_valid !== 1'b0 || count !== '0) begin errors++; $display("[TB] FAIL async_reset got valid %b count %0d exp 0 0", bus.rd_valid, count); end
        q.delete();
        shown = 0;
        set_inputs(0, '0, 0, 0);
        checks++; if (bus.wr_ready !== 1'b0 || ram_cejb_n !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_hold got wr_ready %b cejb_n %b exp 0 1", bus.wr_ready, ram_cejb_n); end
        clock_edge();
        #2 reset = 1'b0;
        set_inputs(1, 16'h5A5A, 0, 0); clock_edge();
        set_inputs(0, '0, 0, 0);       clock_edge();
        set_inputs(0, '0, 1, 0);
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h5A5A || count !== 4'd1) begin errors++; $display("[TB] FAIL async_resume got valid %b data %h count %0d exp 1 5a5a 1", bus.rd_valid, bus.rd_data, count); end
        clock_edge();
    endtask

    task automatic test_random();
        bit wv, rr, fl;
        for (int i = 0; i < 300; i++) begin
            wv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 1) != 0);
            fl = ($urandom_range(0, 40) == 0);
            set_inputs(wv, DW'($urandom), rr, fl);
            checks++; if (bus.rd_valid !== exp_rd_valid) begin errors++; $display("[TB] FAIL rand_valid c%0d got %b exp %b", i, bus.rd_valid, exp_rd_valid); end
            checks++; if (count !== exp_count) begin errors++; $display("[TB] FAIL rand_count c%0d got %0d exp %0d", i, count, exp_count); end
            checks++; if (bus.wr_ready !== exp_wr_ready) begin errors++; $display("[TB] FAIL rand_wr_ready c%0d got %b exp %b", i, bus.wr_ready, exp_wr_ready); end
            checks++; if (ram_ceia_n !== exp_ceia_n || ram_cejb_n !== exp_cejb_n) begin errors++; $display("[TB] FAIL rand_enables c%0d got %b%b exp %b%b", i, ram_ceia_n, ram_cejb_n, exp_ceia_n, exp_cejb_n); end
            if (exp_rd_valid) begin
                checks++; if (bus.rd_data !== exp_head) begin errors++; $display("[TB] FAIL rand_data c%0d got %h exp %h", i, bus.rd_data, exp_head); end
            end
            clock_edge();
        end
    endtask

    // Watchdog so the run always ends even if a task stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence
    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_fill();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rpc2_ctrl_dpram_fifo_ctrl.md
# rpc2_ctrl_dpram_fifo_ctrl

Single-clock FIFO controller that sequences one `rpc2_ctrl_dpram_generator` instance (write port A, registered read port B) as a first-word-fall-through FIFO with valid/ready handshakes on both sides. It owns the write/read pointers, occupancy, full/empty and flush. It drives the RAM chip-enables and addresses. The read data path is the RAM's registered output, so no extra data register is needed. It is used wherever the controller needs a same-clock FIFO, for example ID and response queues.

## Interface
- `FIFO_ADDR_BITS`, 3: RAM address width. RAM depth is D = 2^FIFO_ADDR_BITS, and the value must be ≥ 1.
- `FIFO_DATA_WIDTH`, 16: data width.

- `clk`  in  1  single clock. Both RAM ports are connected to this clock.
- `reset`  in  1  asynchronous reset, active-high.
- `flush`  in  1  synchronous clear of FIFO contents.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  the controller can accept a write.
- `wr_data`  in  FIFO_DATA_WIDTH  write data.
- `rd_valid`  out  1  `rd_data` holds the head entry.
- `rd_ready`  in  1  the consumer takes the head entry.
- `rd_data`  out  FIFO_DATA_WIDTH  head entry, equal to `ram_odata`.
- `count`  out  FIFO_ADDR_BITS+1  total entries, range 0..D+1.
- `ram_ceia_n`  out  1  RAM port A enable, active-low.
- `ram_ia`  out  FIFO_ADDR_BITS  RAM write address.
- `ram_idata`  out  FIFO_DATA_WIDTH  RAM write data, equal to `wr_data`.
- `ram_cejb_n`  out  1  RAM port B enable, active-low.
- `ram_jb`  out  FIFO_ADDR_BITS  RAM read address.
- `ram_odata`  in  FIFO_DATA_WIDTH  RAM port B registered output. It holds its value while `ram_cejb_n` = 1.

## Operation
- **State registers:**
  - `wptr`, `rptr`: FIFO_ADDR_BITS wide, wrap modulo D.
  - `ram_words`: FIFO_ADDR_BITS+1 wide, range 0..D, the number of words written to the RAM but not yet read from it.
  - `rd_valid`.
- **Reset:** `reset` = 1 asynchronously clears `wptr`, `rptr`, `ram_words` and `rd_valid`.
- **Write side:**
  - `wr_ready` = !reset & !flush & (ram_words != D).
  - `wr_fire` = wr_valid & wr_ready.
  - `ram_ceia_n` = !wr_fire, `ram_ia` = `wptr`, `ram_idata` = `wr_data`.
  - On `wr_fire`, `wptr` increments.
  - A write with `wr_ready` = 0 is ignored: no RAM write and no state change.
- **Read issue:**
  - `rd_fire` = rd_valid & rd_ready.
  - `rd_issue` = !reset & !flush & (ram_words != 0) & (!rd_valid | rd_ready).
  - `ram_cejb_n` = !rd_issue, `ram_jb` = `rptr`.
  - On `rd_issue`, `rptr` increments.
- **Output valid:** the next value of `rd_valid` is `rd_issue` | (rd_valid & !rd_ready).
  - A head entry that is not taken stays valid.
  - Its data holds because the RAM output is not re-enabled.
- **Occupancy:** the next value of `ram_words` is ram_words + wr_fire − rd_issue.
  - A simultaneous write and read issue leaves it unchanged.
  - `ram_words` never goes below 0 or above D.
- **Outputs:** `count` = ram_words + rd_valid, so the FIFO capacity is D+1 (D words in RAM plus the head word on the RAM output).
- **Read-during-write:** a word is never read in the same cycle it is written, because `ram_words` counts only words written at a previous edge. Same-address read and write collisions therefore cannot occur.
- **Flush:** at the edge where `flush` = 1:
  - `wptr`, `rptr`, `ram_words` and `rd_valid` clear to 0.
  - `wr_ready` = 0 and `rd_issue` = 0 during that cycle.
  - A `rd_fire` in the flush cycle is still a valid transfer of the current head.
- **Wrap-around:** pointers wrap from D−1 to 0 with no special handling.

## Timing
- Reset values: `wr_ready` = 0 while reset is high, then 1. `rd_valid` = 0, `count` = 0, `ram_ceia_n` = 1, `ram_cejb_n` = 1. `ram_ia` = 0, `ram_jb` = 0. `rd_data` is undefined while `rd_valid` = 0.
- Write to read latency: for a write accepted at edge T into an empty FIFO, `rd_issue` = 1 in cycle T+1 and `rd_valid` = 1 with valid `rd_data` from edge T+1 (2 edges after the write).
- Throughput: one write and one read per cycle sustained. With `rd_ready` held at 1, back-to-back reads have no bubbles.
- `wr_ready`, `rd_valid` and `count` depend only on registers plus `reset` and `flush`. There is no combinational path from `wr_valid` to `wr_ready`.
- `ram_cejb_n` depends combinationally on `rd_ready`. `ram_ceia_n` depends combinationally on `wr_valid`.

## Test plan
- Reset, then idle: `rd_valid` = 0, `count` = 0, `wr_ready` = 1, both RAM enables = 1 for 5 cycles.
- With D = 8 and `rd_ready` = 0, write 0x0001..0x0009:
  - First write (0x0001): `rd_valid` rises 2 edges later with `rd_data` = 0x0001.
  - After the 9th accepted write: `wr_ready` = 0 and `count` = 9.
  - A 10th write of 0x000A is ignored.
  - Then set `rd_ready` = 1: data 0x0001..0x0009 is read in order on 9 consecutive cycles, and `count` reaches 0.
- Streaming with `wr_valid` and `rd_ready` held at 1 for 40 cycles on an incrementing pattern: after the initial 2-cycle latency, one output per cycle with no gaps. `count` stays at 1 or 2. Pointers wrap 5 times with no data errors.
- Backpressure: with the head 0x00AA valid, hold `rd_ready` = 0 for 4 cycles while writing 0x00BB. `rd_data` stays 0x00AA and `ram_cejb_n` = 1 throughout. With `rd_ready` = 1, 0x00BB follows in the next cycle.
- Flush with 5 entries queued, `rd_ready` = 0: one cycle after the flush edge, `count` = 0, `rd_valid` = 0, `wr_ready` = 1. A subsequent write of 0x1234 reads back as 0x1234.
- Asynchronous reset asserted mid-stream, between clock edges: `rd_valid` and `count` go to 0 immediately without a clock edge. After release, normal operation resumes from empty.
